// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: top-level run sequencer and single-port SRAM owner.
// The UART upload ends when the port has been idle for RX_IDLE_CYCLES cycles.
// Stages then run in index order, skipping any stage whose bit is set in
// stage_skip. Outside a run the VGA reader owns the SRAM port.
// Optional feature macro: SEQ_WATCHDOG_EN (per-stage watchdog, sticky stage_error).
`timescale 1ns/1ps

module sram_stage_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int RX_IDLE_CYCLES = 50000000,
  parameter int WDOG_CYCLES    = 16777216,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         UART_RX_I,
  input  logic                         run_request,
  input  logic [NUM_STAGES-1:0]        stage_skip,
  input  logic [ADDR_W-1:0]            UART_SRAM_address,
  input  logic [DATA_W-1:0]            UART_SRAM_write_data,
  input  logic                         UART_SRAM_we_n,
  output logic                         UART_rx_initialize,
  output logic                         UART_rx_enable,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_SRAM_address,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_SRAM_write_data,
  input  logic [NUM_STAGES-1:0]        stage_SRAM_we_n,
  input  logic [ADDR_W-1:0]            VGA_SRAM_address,
  output logic                         VGA_enable,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic                         busy,
  output logic [IDX_W-1:0]             current_stage,
  output logic                         stage_error
);

  localparam int TIMER_W = $clog2(RX_IDLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_LAUNCH, S_WAIT} state_t;

  state_t                r_state, w_state_next;
  logic [IDX_W-1:0]      r_stage, w_stage_next;
  logic [NUM_STAGES-1:0] r_skip, w_skip_next;
  logic [TIMER_W-1:0]    r_timer, w_timer_next;
  logic                  r_init, w_init_next;
  logic                  r_en, w_en_next;
  logic                  r_vga, w_vga_next;

  logic                  w_rx_timeout;
  logic                  w_first_found;
  logic [IDX_W-1:0]      w_first_idx;
  logic                  w_next_found;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_wdog_abort;

  logic [ADDR_W-1:0]     w_stg_addr [NUM_STAGES];
  logic [DATA_W-1:0]     w_stg_data [NUM_STAGES];

  // Unpack the flat per-stage SRAM buses and form the one-hot start pulse.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign w_stg_addr[gi]  = stage_SRAM_address[gi*ADDR_W +: ADDR_W];
      assign w_stg_data[gi]  = stage_SRAM_write_data[gi*DATA_W +: DATA_W];
      assign stage_start[gi] = (r_state == S_LAUNCH) && (r_stage == IDX_W'(gi));
    end
  endgenerate

  assign w_rx_timeout = (r_timer == TIMER_W'(RX_IDLE_CYCLES - 1));

  // Lowest non-skipped stage of the mask about to be latched for a new run.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!stage_skip[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest non-skipped stage strictly above the one currently running.
  always_comb begin
    w_next_found = 1'b0;
    w_next_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!r_skip[i] && (i > int'(r_stage))) begin
        w_next_found = 1'b1;
        w_next_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and registered-output logic of the run sequencer.
  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_skip_next  = r_skip;
    w_timer_next = r_timer;
    w_init_next  = r_init;
    w_en_next    = r_en;
    w_vga_next   = r_vga;
    case (r_state)
      S_IDLE: begin
        // A falling UART line outranks a simultaneous software re-run.
        if (!UART_RX_I) begin
          w_init_next  = 1'b1;
          w_vga_next   = 1'b0;
          w_timer_next = '0;
          w_state_next = S_RX;
        end else if (run_request) begin
          w_skip_next = stage_skip;
          if (w_first_found) begin
            w_stage_next = w_first_idx;
            w_vga_next   = 1'b0;
            w_state_next = S_LAUNCH;
          end
        end
      end
      S_RX: begin
        w_init_next = 1'b0;
        w_en_next   = 1'b1;
        if (!UART_SRAM_we_n) begin
          w_timer_next = '0;
        end else if (w_rx_timeout) begin
          w_skip_next = stage_skip;
          w_en_next   = 1'b0;
          if (w_first_found) begin
            w_stage_next = w_first_idx;
            w_state_next = S_LAUNCH;
          end else begin
            w_vga_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_LAUNCH: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Only the running stage's done bit matters here.
        if (stage_done[r_stage]) begin
          if (w_next_found) begin
            w_stage_next = w_next_idx;
            w_state_next = S_LAUNCH;
          end else begin
            w_stage_next = '0;
            w_vga_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (w_wdog_abort) begin
          w_stage_next = '0;
          w_vga_next   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_skip  <= '0;
      r_timer <= '0;
      r_init  <= 1'b0;
      r_en    <= 1'b0;
      r_vga   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_stage <= w_stage_next;
      r_skip  <= w_skip_next;
      r_timer <= w_timer_next;
      r_init  <= w_init_next;
      r_en    <= w_en_next;
      r_vga   <= w_vga_next;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_inc;
  logic              r_error;
  logic              w_run_begin;

  // The limit counts the start cycle too, so a stage gets WDOG_CYCLES cycles.
  assign w_wdog_inc   = r_wdog + 1'b1;
  assign w_wdog_abort = (r_state == S_WAIT) && (w_wdog_inc == WDOG_W'(WDOG_CYCLES - 1));
  assign w_run_begin  = ((r_state == S_IDLE) && UART_RX_I && run_request) ||
                        ((r_state == S_RX) && UART_SRAM_we_n && w_rx_timeout);

  // Per-stage cycle counter and sticky abort flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT) begin
        r_wdog <= w_wdog_inc;
      end
      if (w_run_begin) begin
        r_error <= 1'b0;
      end else if (w_wdog_abort && !stage_done[r_stage]) begin
        r_error <= 1'b1;
      end
    end
  end

  assign stage_error = r_error;
`else
  // No watchdog: a stage may take as long as it likes and never errors.
  assign w_wdog_abort = 1'b0;
  assign stage_error  = (WDOG_CYCLES < 0);
`endif

  // SRAM port ownership follows the phase.
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (r_state)
      S_RX: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_LAUNCH, S_WAIT: begin
        SRAM_address    = w_stg_addr[r_stage];
        SRAM_write_data = w_stg_data[r_stage];
        SRAM_we_n       = stage_SRAM_we_n[r_stage];
      end
      default: begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

  assign UART_rx_initialize = r_init;
  assign UART_rx_enable     = r_en;
  assign VGA_enable         = r_vga;
  assign busy               = (r_state != S_IDLE);
  assign current_stage      = r_stage;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer: reset, upload timeout, ordered
// stage launches, skip mask, ignored inputs, reset mid-run and (when
// SEQ_WATCHDOG_EN is defined) the watchdog abort.
`timescale 1ns/1ps

module tb_sram_stage_sequencer;

  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          run_req = 1'b0;
  logic [NS-1:0] skip = '0;
  logic [AW-1:0] uart_addr = '0;
  logic [DW-1:0] uart_data = '0;
  logic          uart_we_n = 1'b1;
  logic          rx_init;
  logic          rx_en;
  logic [NS-1:0] start;
  logic [NS-1:0] done = '0;
  logic [NS*AW-1:0] stg_addr = {18'h00102, 18'h00101, 18'h00100};
  logic [NS*DW-1:0] stg_data = {16'hA002, 16'hA001, 16'hA000};
  logic [NS-1:0] stg_we_n = 3'b101;
  logic [AW-1:0] vga_addr = 18'h02BCD;
  logic          vga_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          sram_we_n;
  logic          busy;
  logic [1:0]    cur;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  sram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW),
    .RX_IDLE_CYCLES(100), .WDOG_CYCLES(64)
  ) dut (
    .Clock(clk), .Reset(rst), .UART_RX_I(uart_rx), .run_request(run_req),
    .stage_skip(skip), .UART_SRAM_address(uart_addr),
    .UART_SRAM_write_data(uart_data), .UART_SRAM_we_n(uart_we_n),
    .UART_rx_initialize(rx_init), .UART_rx_enable(rx_en),
    .stage_start(start), .stage_done(done),
    .stage_SRAM_address(stg_addr), .stage_SRAM_write_data(stg_data),
    .stage_SRAM_we_n(stg_we_n), .VGA_SRAM_address(vga_addr),
    .VGA_enable(vga_en), .SRAM_address(sram_addr),
    .SRAM_write_data(sram_data), .SRAM_we_n(sram_we_n),
    .busy(busy), .current_stage(cur), .stage_error(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    $display("reset: released");
    if (vga_en !== 1'b1) $display("FAIL reset_vga_en: got %0b want 1", vga_en); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++;
    if (start !== 3'b000) $display("FAIL reset_start: got %b want 000", start); else n_pass++;
    n_checks++;
    if (rx_init !== 1'b0 || rx_en !== 1'b0) $display("FAIL reset_uart: got init %0b en %0b want 0 0", rx_init, rx_en); else n_pass++;
    n_checks++;
    if (cur !== 2'd0 || err !== 1'b0) $display("FAIL reset_stage_err: got cur %0d err %0b want 0 0", cur, err); else n_pass++;
    n_checks++;
    if (sram_addr !== 18'h02BCD || sram_we_n !== 1'b1 || sram_data !== 16'h0)
      $display("FAIL reset_sram_mux: got %h/%h/%0b want 02bcd/0000/1", sram_addr, sram_data, sram_we_n);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_upload;
    uart_rx = 1'b0;
    tick();
    if (rx_init !== 1'b1 || rx_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL upload_init: got init %0b en %0b busy %0b want 1 0 1", rx_init, rx_en, busy);
    else n_pass++;
    n_checks++;
    uart_rx = 1'b1;
    tick();
    if (rx_init !== 1'b0 || rx_en !== 1'b1)
      $display("FAIL upload_enable: got init %0b en %0b want 0 1", rx_init, rx_en);
    else n_pass++;
    n_checks++;
    for (int n = 0; n < 5; n++) begin
      uart_addr = 18'h03000 + 18'(n);
      uart_data = 16'h5500 + 16'(n);
      uart_we_n = 1'b0;
      #1;
      $display("upload: write %0d addr %h data %h", n, uart_addr, uart_data);
      if (sram_addr !== uart_addr || sram_data !== uart_data || sram_we_n !== 1'b0)
        $display("FAIL upload_mux_%0d: got %h/%h/%0b want %h/%h/0", n, sram_addr, sram_data, sram_we_n, uart_addr, uart_data);
      else n_pass++;
      n_checks++;
      tick();
      uart_we_n = 1'b1;
      if (n < 4) repeat (49) tick();
    end
    repeat (99) tick();
    if (start !== 3'b000 || rx_en !== 1'b1)
      $display("FAIL upload_early: got start %b en %0b want 000 1", start, rx_en);
    else n_pass++;
    n_checks++;
    tick();
    if (start !== 3'b001 || rx_en !== 1'b0)
      $display("FAIL upload_timeout_start: got start %b en %0b want 001 0", start, rx_en);
    else n_pass++;
    n_checks++;
  endtask

  // Entered with stage 0 in its launch cycle.
  task automatic test_run_order;
    logic [2:0] exp_oh;
    for (int s = 0; s < 3; s++) begin
      exp_oh = 3'b001 << s;
      $display("run: stage %0d start %b", s, start);
      if (start !== exp_oh || cur !== 2'(s))
        $display("FAIL order_start_%0d: got start %b cur %0d want %b %0d", s, start, cur, exp_oh, s);
      else n_pass++;
      n_checks++;
      if (sram_addr !== 18'h00100 + 18'(s) || sram_data !== 16'hA000 + 16'(s) || sram_we_n !== (s == 1 ? 1'b0 : 1'b1))
        $display("FAIL order_mux_%0d: got %h/%h/%0b", s, sram_addr, sram_data, sram_we_n);
      else n_pass++;
      n_checks++;
      tick();
      if (start !== 3'b000) $display("FAIL order_pulse_%0d: got %b want 000", s, start); else n_pass++;
      n_checks++;
      repeat (18) tick();
      done = exp_oh;
      tick();
      done = '0;
    end
    if (busy !== 1'b0 || vga_en !== 1'b1 || sram_addr !== 18'h02BCD || sram_we_n !== 1'b1)
      $display("FAIL order_idle: got busy %0b vga %0b addr %h we_n %0b want 0 1 02bcd 1", busy, vga_en, sram_addr, sram_we_n);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_skip;
    skip = 3'b010;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    skip = 3'b000;
    $display("skip: mask 010 start %b", start);
    if (start !== 3'b001) $display("FAIL skip_first: got %b want 001", start); else n_pass++;
    n_checks++;
    repeat (4) tick();
    done = 3'b001;
    tick();
    done = '0;
    if (start !== 3'b100 || cur !== 2'd2) $display("FAIL skip_jump: got start %b cur %0d want 100 2", start, cur); else n_pass++;
    n_checks++;
    tick();
    done = 3'b100;
    tick();
    done = '0;
    if (busy !== 1'b0 || vga_en !== 1'b1) $display("FAIL skip_done: got busy %0b vga %0b want 0 1", busy, vga_en); else n_pass++;
    n_checks++;
    skip = 3'b111;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    skip = 3'b000;
    $display("skip: mask 111 start %b busy %0b", start, busy);
    if (start !== 3'b000 || busy !== 1'b0 || vga_en !== 1'b1)
      $display("FAIL skip_all: got start %b busy %0b vga %0b want 000 0 1", start, busy, vga_en);
    else n_pass++;
    n_checks++;
    tick();
    if (start !== 3'b000) $display("FAIL skip_all_later: got %b want 000", start); else n_pass++;
    n_checks++;
  endtask

  task automatic test_ignored;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    done = 3'b001;
    tick();
    done = '0;
    tick();
    $display("ignored: done during launch, start %b cur %0d", start, cur);
    if (start !== 3'b000 || cur !== 2'd0 || busy !== 1'b1)
      $display("FAIL ignore_launch_done: got start %b cur %0d busy %0b want 000 0 1", start, cur, busy);
    else n_pass++;
    n_checks++;
    done = 3'b100;
    tick();
    done = '0;
    tick();
    if (start !== 3'b000 || cur !== 2'd0) $display("FAIL ignore_other_done: got start %b cur %0d want 000 0", start, cur); else n_pass++;
    n_checks++;
    run_req = 1'b1;
    uart_rx = 1'b0;
    tick();
    run_req = 1'b0;
    uart_rx = 1'b1;
    tick();
    if (rx_init !== 1'b0 || start !== 3'b000 || cur !== 2'd0 || busy !== 1'b1 || err !== 1'b0)
      $display("FAIL ignore_requests: got init %0b start %b cur %0d busy %0b err %0b", rx_init, start, cur, busy, err);
    else n_pass++;
    n_checks++;
    done = 3'b001;
    tick();
    done = '0;
    if (start !== 3'b010) $display("FAIL ignore_resume: got %b want 010", start); else n_pass++;
    n_checks++;
    tick();
    done = 3'b010;
    tick();
    done = '0;
    tick();
    done = 3'b100;
    tick();
    done = '0;
    if (busy !== 1'b0) $display("FAIL ignore_finish: got busy %0b want 0", busy); else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_midrun;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("reset_midrun: start %b busy %0b", start, busy);
    if (start !== 3'b000 || busy !== 1'b0 || vga_en !== 1'b1 || cur !== 2'd0)
      $display("FAIL midrun_reset: got start %b busy %0b vga %0b cur %0d want 000 0 1 0", start, busy, vga_en, cur);
    else n_pass++;
    n_checks++;
    tick();
    rst = 1'b0;
    tick();
    if (busy !== 1'b0 || start !== 3'b000) $display("FAIL midrun_release: got busy %0b start %b", busy, start); else n_pass++;
    n_checks++;
  endtask

`ifdef SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    logic saw2;
    saw2 = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (5) tick();
    done = 3'b001;
    tick();
    done = '0;
    $display("watchdog: stage 1 start %b", start);
    if (start !== 3'b010) $display("FAIL wdog_start1: got %b want 010", start); else n_pass++;
    n_checks++;
    repeat (63) begin
      tick();
      if (start[2]) saw2 = 1'b1;
    end
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL wdog_early: got err %0b busy %0b want 0 1", err, busy); else n_pass++;
    n_checks++;
    tick();
    if (err !== 1'b1 || busy !== 1'b0 || vga_en !== 1'b1)
      $display("FAIL wdog_abort: got err %0b busy %0b vga %0b want 1 0 1", err, busy, vga_en);
    else n_pass++;
    n_checks++;
    repeat (5) begin
      tick();
      if (start[2]) saw2 = 1'b1;
    end
    if (saw2 !== 1'b0 || err !== 1'b1) $display("FAIL wdog_abandon: got saw2 %0b err %0b want 0 1", saw2, err); else n_pass++;
    n_checks++;
    skip = 3'b111;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    skip = 3'b000;
    if (err !== 1'b0) $display("FAIL wdog_clear: got %0b want 0", err); else n_pass++;
    n_checks++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_upload();
    test_run_order();
    test_skip();
    test_ignored();
    test_reset_midrun();
`ifdef SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_stage_sequencer.md
# sram_stage_sequencer

Parametrised top-level sequencer and SRAM owner for the decoder pipeline. Waits for a UART upload, detects end of upload by an idle timeout, then launches NUM_STAGES processing stages in index order (one-cycle start pulse, wait for done), granting the single SRAM port to whichever agent currently owns the phase. Between runs the SRAM port belongs to the VGA reader. Adds a skip mask, a software re-run request, and an optional per-stage watchdog.

## Interface
- NUM_STAGES, 3, number of processing stages; index 0 runs first
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- RX_IDLE_CYCLES, 50000000, idle cycles after last UART write that end the upload
- WDOG_CYCLES, 16777216, per-stage cycle limit (used only with SEQ_WATCHDOG_EN)
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- UART_RX_I  in  1  raw UART line, idle high
- run_request  in  1  one-cycle pulse: re-run stages on current SRAM contents
- stage_skip  in  NUM_STAGES  1 = stage bypassed; latched when a run begins
- UART_SRAM_address / UART_SRAM_write_data / UART_SRAM_we_n  in  ADDR_W / DATA_W / 1  upload port
- UART_rx_initialize  out  1  UART interface initialise
- UART_rx_enable  out  1  UART interface enable
- stage_start  out  NUM_STAGES  one-hot start pulse
- stage_done  in  NUM_STAGES  per-stage done pulse
- stage_SRAM_address  in  NUM_STAGES*ADDR_W  packed, stage i at [i*ADDR_W +: ADDR_W]
- stage_SRAM_write_data  in  NUM_STAGES*DATA_W  packed likewise
- stage_SRAM_we_n  in  NUM_STAGES  per-stage write enable, active low
- VGA_SRAM_address  in  ADDR_W  display reader address
- VGA_enable  out  1  display reader enable
- SRAM_address / SRAM_write_data / SRAM_we_n  out  ADDR_W / DATA_W / 1  muxed SRAM port
- busy  out  1  high in any state other than S_IDLE
- current_stage  out  $clog2(NUM_STAGES) (min 1)  index of stage owning SRAM
- stage_error  out  1  sticky watchdog abort flag

## Operation
- States: S_IDLE, S_RX, S_LAUNCH, S_WAIT.
- S_IDLE: VGA_enable=1. UART_RX_I==0 -> UART_rx_initialize<=1, VGA_enable<=0, timer<=0, -> S_RX. Else run_request -> latch stage_skip, VGA_enable<=0, -> S_LAUNCH at lowest non-skipped index. UART_RX_I low takes priority over simultaneous run_request.
- S_RX: UART_rx_initialize cleared on second cycle; UART_rx_enable=1 from second cycle until exit. Timer increments each cycle; any UART_SRAM_we_n==0 clears it. Timer==RX_IDLE_CYCLES-1 -> latch stage_skip, UART_rx_enable<=0, -> S_LAUNCH.
- S_LAUNCH: stage_start[current_stage]=1 for exactly this cycle; -> S_WAIT.
- S_WAIT: only stage_done[current_stage] is observed; other done bits and done during S_LAUNCH are ignored. On done: next non-skipped index > current -> S_LAUNCH; none -> S_IDLE (VGA_enable<=1).
- All stages skipped: run goes S_IDLE directly, no start pulse.
- UART_RX_I and run_request ignored outside S_IDLE.
- SRAM mux (combinational): S_RX -> UART port; S_LAUNCH/S_WAIT -> stage current_stage; S_IDLE -> VGA_SRAM_address, write data 0, we_n 1.
- stage_error cleared only by Reset or by the start of a new run.

## Timing
- Reset: S_IDLE, VGA_enable=1, UART_rx_initialize=0, UART_rx_enable=0, stage_start=0, busy=0, current_stage=0, stage_error=0, timer=0.
- UART line low at edge k -> UART_rx_initialize high k+1, UART_rx_enable high k+2.
- Last upload write at edge k -> S_LAUNCH at k+RX_IDLE_CYCLES, stage_start pulse in that state.
- stage_done at edge k in S_WAIT -> next stage_start pulse at k+1 (two-cycle minimum gap between consecutive starts).
- Reset mid-run: outputs return to reset values immediately; stage_start never left high.

## Configuration
- SEQ_WATCHDOG_EN defined: per-stage counter cleared in S_LAUNCH, increments in S_WAIT; reaching WDOG_CYCLES-1 without done -> stage_error<=1, remaining stages abandoned, -> S_IDLE with VGA_enable=1.
- Undefined: no counter; S_WAIT waits indefinitely; stage_error tied 0.

## Test plan
- Reset with UART_RX_I=1 -> S_IDLE, VGA_enable=1, SRAM_address follows VGA_SRAM_address, SRAM_we_n=1.
- RX_IDLE_CYCLES=100, UART_RX_I low, 5 writes spaced 50 cycles -> stage_start=3'b001 exactly 100 cycles after last write; SRAM port mirrors UART during upload.
- NUM_STAGES=3, done each stage after 20 cycles -> starts 001,010,100 in order; SRAM mux tracks current_stage; return to S_IDLE, VGA_enable=1.
- run_request with stage_skip=3'b010 -> starts only 001 then 100; stage_skip=3'b111 -> no start, back to S_IDLE next cycle.
- stage_done[2] pulsed while stage 0 waiting -> ignored; run_request during S_WAIT -> ignored.
- SEQ_WATCHDOG_EN, WDOG_CYCLES=64, stage 1 never done -> stage_error=1 at 64 cycles after its start, S_IDLE, stage 2 never started.
